// File: rtl/axil_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : axil_master_if
//  Purpose  : Single-outstanding AXI4-Lite initiator behind a valid/ready
//             request/response port. Define AXIL_MASTER_REQ_BUF_EN to add a
//             one-entry request buffer.
//  Revision : 1.0  initial release
// ============================================================================
module axil_master_if #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 16,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0]  AXIL_PROT  = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RD   = 3'd3,
    S_RR   = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_req_hs;
  logic                  w_launch;
  logic                  w_launch_we;
  logic [ADDR_WIDTH-1:0] w_launch_addr;
  logic [DATA_WIDTH-1:0] w_launch_wdata;
  logic [STRB_WIDTH-1:0] w_launch_wstrb;
  logic                  w_req_ready_nxt;

  assign w_req_hs      = req_valid && req_ready;
  assign m_axil_awaddr = r_addr;
  assign m_axil_araddr = r_addr;
  assign m_axil_awprot = AXIL_PROT;
  assign m_axil_arprot = AXIL_PROT;

`ifdef AXIL_MASTER_REQ_BUF_EN
  logic                  r_buf_valid;
  logic                  r_buf_we;
  logic [ADDR_WIDTH-1:0] r_buf_addr;
  logic [DATA_WIDTH-1:0] r_buf_wdata;
  logic [STRB_WIDTH-1:0] r_buf_wstrb;
  logic                  w_buf_pop;
  logic                  w_buf_push;
  logic                  w_buf_valid_nxt;

  // Requests arriving while busy park in the buffer; an idle engine with an
  // empty buffer launches straight from the port to keep one-cycle latency.
  always_comb begin
    w_buf_pop       = (r_state == S_IDLE) && r_buf_valid;
    w_buf_push      = w_req_hs && (r_state != S_IDLE);
    w_launch        = w_buf_pop || ((r_state == S_IDLE) && w_req_hs);
    w_launch_we     = r_buf_valid ? r_buf_we    : req_we;
    w_launch_addr   = r_buf_valid ? r_buf_addr  : req_addr;
    w_launch_wdata  = r_buf_valid ? r_buf_wdata : req_wdata;
    w_launch_wstrb  = r_buf_valid ? r_buf_wstrb : req_wstrb;
    w_buf_valid_nxt = r_buf_valid ? !w_buf_pop : w_buf_push;
    w_req_ready_nxt = !w_buf_valid_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_we    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
      r_buf_wstrb <= '0;
    end else begin
      r_buf_valid <= w_buf_valid_nxt;
      if (w_buf_push) begin
        r_buf_we    <= req_we;
        r_buf_addr  <= req_addr;
        r_buf_wdata <= req_wdata;
        r_buf_wstrb <= req_wstrb;
      end
    end
  end
`else
  always_comb begin
    w_launch        = (r_state == S_IDLE) && w_req_hs;
    w_launch_we     = req_we;
    w_launch_addr   = req_addr;
    w_launch_wdata  = req_wdata;
    w_launch_wstrb  = req_wstrb;
    w_req_ready_nxt = ((r_state == S_IDLE) && !w_launch) ||
                      ((r_state == S_RSP) && rsp_ready);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      req_ready <= w_req_ready_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_addr       <= w_launch_addr;
            m_axil_wdata <= w_launch_wdata;
            m_axil_wstrb <= w_launch_wstrb;
            if (w_launch_we) begin
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              r_state        <= S_WR;
            end else begin
              m_axil_arvalid <= 1'b1;
              r_state        <= S_RD;
            end
          end
        end
        S_WR: begin
          // AW and W retire independently; move on once neither is pending.
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          if ((!m_axil_awvalid || m_axil_awready) &&
              (!m_axil_wvalid  || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            r_state       <= S_WB;
          end
        end
        S_WB: begin
          if (m_axil_bvalid) begin
            rsp_err       <= |m_axil_bresp;
            rsp_rdata     <= '0;
            m_axil_bready <= 1'b0;
            rsp_valid     <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RD: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            r_state        <= S_RR;
          end
        end
        S_RR: begin
          if (m_axil_rvalid) begin
            rsp_rdata     <= m_axil_rdata;
            rsp_err       <= |m_axil_rresp;
            m_axil_rready <= 1'b0;
            rsp_valid     <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_master_if
//  Purpose  : Directed self-checking bench for axil_master_if with a
//             configurable-latency AXI4-Lite RAM responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axil_master_if;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
    .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot),
    .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder configuration, driven from the stimulus block.
  int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic        rovr_en;
  logic [31:0] rovr_data;

  logic [31:0] mem [0:255];
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [15:0] aw_q;
  logic [31:0] wd_q, rd_q;
  logic [3:0]  ws_q;
  logic        aw_hs, w_hs, ag, wg;
  logic [15:0] wa;
  logic [31:0] wdat;
  logic [3:0]  wstb;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = b_pend  && (b_cnt  >= b_dly);
  assign rvalid  = r_pend  && (r_cnt  >= r_dly);
  assign bresp   = bresp_cfg;
  assign rresp   = rresp_cfg;
  assign rdata   = rd_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ag      = aw_got || aw_hs;
  assign wg      = w_got || w_hs;
  assign wa      = aw_hs ? awaddr : aw_q;
  assign wdat    = w_hs ? wdata : wd_q;
  assign wstb    = w_hs ? wstrb : ws_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_q <= '0; wd_q <= '0; ws_q <= '0; rd_q <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      b_cnt  <= b_pend ? b_cnt + 1 : 0;
      r_cnt  <= r_pend ? r_cnt + 1 : 0;
      if (bvalid && bready) b_pend <= 1'b0;
      if (rvalid && rready) r_pend <= 1'b0;
      if (ag && wg) begin
        for (int i = 0; i < 4; i++)
          if (wstb[i]) mem[wa[9:2]][8*i +: 8] <= wdat[8*i +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        b_pend <= 1'b1; b_cnt <= 0;
      end else begin
        aw_got <= ag; w_got <= wg;
        aw_q <= wa; wd_q <= wdat; ws_q <= wstb;
      end
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= 0;
        rd_q   <= rovr_en ? rovr_data : mem[araddr[9:2]];
      end
    end
  end

  // Handshake counters and valid/payload stability monitor.
  int          n_aw, n_w, n_b, n_ar, n_r, n_rsp, viol;
  logic        p_aw, p_w, p_ar, p_rsp;
  logic [15:0] q_awaddr, q_araddr;
  logic [35:0] q_w;
  logic [32:0] q_rsp;

  initial begin
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_rsp = 0; viol = 0;
  end

  always @(posedge clk) begin
    n_aw  <= n_aw  + int'(aw_hs);
    n_w   <= n_w   + int'(w_hs);
    n_b   <= n_b   + int'(bvalid && bready);
    n_ar  <= n_ar  + int'(arvalid && arready);
    n_r   <= n_r   + int'(rvalid && rready);
    n_rsp <= n_rsp + int'(rsp_valid && rsp_ready);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0; p_rsp <= 1'b0;
      q_awaddr <= '0; q_araddr <= '0; q_w <= '0; q_rsp <= '0;
    end else begin
      viol <= viol
            + int'(p_aw  && (!awvalid || awaddr != q_awaddr))
            + int'(p_w   && (!wvalid  || {wstrb, wdata} != q_w))
            + int'(p_ar  && (!arvalid || araddr != q_araddr))
            + int'(p_rsp && (!rsp_valid || {rsp_err, rsp_rdata} != q_rsp));
      p_aw  <= awvalid && !awready;
      p_w   <= wvalid && !wready;
      p_ar  <= arvalid && !arready;
      p_rsp <= rsp_valid && !rsp_ready;
      q_awaddr <= awaddr; q_araddr <= araddr;
      q_w      <= {wstrb, wdata};
      q_rsp    <= {rsp_err, rsp_rdata};
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_accept_in_time", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_in_time", 64'(n < 100), 64'd1);
    lat = n + 1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop_and_ready", {62'd0, rsp_valid, req_ready}, 64'b01);
  endtask

  task automatic do_txn(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic err, output int lat);
    send_req(we, a, d, s);
    wait_rsp(lat);
    rd  = rsp_rdata;
    err = rsp_err;
    finish_rsp();
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          c_aw, c_w, c_b, c_ar, c_r, c_rsp;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rovr_en = 1'b0; rovr_data = '0;

    repeat (2) @(posedge clk); #1;
    check("reset_ctrl", {56'd0, req_ready, rsp_valid, rsp_err, awvalid, wvalid,
                         bready, arvalid, rready}, 64'd0);
    check("reset_data", {rsp_rdata, awaddr, wstrb}, 64'd0);
    rst = 1'b0;
    check("ready_before_first_edge", req_ready, 1'b0);
    @(posedge clk); #1;
    check("ready_after_first_edge", req_ready, 1'b1);
    check("prot", {awprot, arprot}, 6'd0);

    // Full write: channel valids one cycle after acceptance, rsp at cycle 3.
    send_req(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    check("wr_valids_cycle1", {awvalid, wvalid, arvalid, req_ready}, 4'b1100);
    check("wr_payload", {awaddr, wstrb, wdata}, {16'h0010, 4'hF, 32'hDEADBEEF});
    wait_rsp(lat);
    check("wr_latency", lat, 3);
    check("wr_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'h0});
    finish_rsp();

    do_txn(1'b0, 16'h0010, 32'h0, 4'h0, rd, err, lat);
    check("rd_back", {err, rd}, {1'b0, 32'hDEADBEEF});
    check("rd_latency", lat, 3);

    // Byte-lane write into byte 1 only.
    do_txn(1'b1, 16'h0010, 32'h0000AB00, 4'b0010, rd, err, lat);
    do_txn(1'b0, 16'h0010, 32'h0, 4'h0, rd, err, lat);
    check("partial_wr", {err, rd}, {1'b0, 32'hDEADABEF});

    // Stalled W channel then stalled R channel.
    c_aw = n_aw; c_w = n_w; c_b = n_b; c_ar = n_ar; c_r = n_r; c_rsp = n_rsp;
    w_dly = 3;
    do_txn(1'b1, 16'h0020, 32'h11223344, 4'hF, rd, err, lat);
    check("stall_wr_latency", lat, 6);
    check("stall_wr_hs", {n_aw - c_aw, n_w - c_w, n_b - c_b}, {32'd1, 32'd1, 32'd1});
    w_dly = 0; r_dly = 5;
    do_txn(1'b0, 16'h0020, 32'h0, 4'h0, rd, err, lat);
    check("stall_rd_data", {err, rd}, {1'b0, 32'h11223344});
    check("stall_rd_latency", lat, 8);
    check("stall_rd_hs", {n_ar - c_ar, n_r - c_r}, {32'd1, 32'd1});
    check("stall_rsp_count", n_rsp - c_rsp, 2);
    r_dly = 0;

    // Error responses.
    bresp_cfg = 2'b10;
    do_txn(1'b1, 16'h0040, 32'h00005555, 4'hF, rd, err, lat);
    check("bresp_err", {err, rd}, {1'b1, 32'h0});
    bresp_cfg = 2'b00; rresp_cfg = 2'b11; rovr_en = 1'b1; rovr_data = 32'h12345678;
    do_txn(1'b0, 16'h0040, 32'h0, 4'h0, rd, err, lat);
    check("rresp_err", {err, rd}, {1'b1, 32'h12345678});
    rresp_cfg = 2'b00; rovr_en = 1'b0;

    // Response back-pressure for 4 cycles.
    c_rsp = n_rsp;
    send_req(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(lat);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("hold_stable", {rsp_valid, rsp_err, req_ready, rsp_rdata},
            {1'b1, 1'b0, 1'b0, 32'hDEADABEF});
    end
    finish_rsp();
    check("hold_one_rsp", n_rsp - c_rsp, 1);

    // Reset in the middle of a write.
    aw_dly = 20; w_dly = 20;
    c_aw = n_aw; c_rsp = n_rsp;
    send_req(1'b1, 16'h0030, 32'hA5A5A5A5, 4'hF);
    @(posedge clk); #1;
    check("midwr_awvalid", {awvalid, wvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("midwr_async_clear", {req_ready, rsp_valid, awvalid, wvalid, bready,
                                arvalid, rready}, 7'd0);
    @(posedge clk); #1;
    rst = 1'b0; aw_dly = 0; w_dly = 0;
    repeat (5) @(posedge clk); #1;
    check("midwr_no_rsp", {n_rsp - c_rsp, n_aw - c_aw}, 64'd0);
    check("midwr_idle_ready", {rsp_valid, req_ready}, 2'b01);
    do_txn(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, rd, err, lat);
    check("post_rst_wr", {err, lat}, {1'b0, 32'd3});
    do_txn(1'b0, 16'h0030, 32'h0, 4'h0, rd, err, lat);
    check("post_rst_rd", {err, rd}, {1'b0, 32'hCAFEF00D});

    check("valid_payload_stability", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axil_master_if.md
Name: axil_master_if

Overview:
- Single-outstanding AXI4-Lite initiator that converts a simple valid/ready memory request port (core/cache side) into AXI4-Lite read or write transactions.
- Returns one response per request, carrying read data and an error flag.
- Sits between the CPU memory stage and AXI-Lite responders such as the on-chip RAM or peripheral slaves.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 16, address bus width in bits
STRB_WIDTH, DATA_WIDTH/8, write strobe width
AXIL_PROT, 3'b000, constant value driven on awprot/arprot

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address, passed unmodified
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  STRB_WIDTH  write byte enables
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  1 when bresp/rresp != 2'b00
m_axil_awaddr/awprot/awvalid out, awready in  ADDR_WIDTH/3/1/1  AW channel
m_axil_wdata/wstrb/wvalid out, wready in  DATA_WIDTH/STRB_WIDTH/1/1  W channel
m_axil_bresp in, bvalid in, bready out  2/1/1  B channel
m_axil_araddr/arprot/arvalid out, arready in  ADDR_WIDTH/3/1/1  AR channel
m_axil_rdata in, rresp in, rvalid in, rready out  DATA_WIDTH/2/1/1  R channel

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all m_axil valid/ready outputs=0, address/data registers=0, state=IDLE. req_ready rises on the first clk edge after rst deasserts.
- All outputs are registered.
- States and transitions:
  - IDLE: req_ready=1. On a request handshake, capture addr/wdata/wstrb. If req_we=1, go to WR with awvalid=wvalid=1; otherwise go to RD with arvalid=1. Channel valids assert the cycle after acceptance.
  - WR: awvalid and wvalid drop independently on their own handshakes, in any order or together. When both are done, go to WB with bready=1.
  - WB: on bvalid, capture rsp_err=|bresp, set rsp_rdata=0, drop bready, go to RSP.
  - RD: on arready, drop arvalid, go to RR with rready=1.
  - RR: on rvalid, capture rdata and rsp_err=|rresp, drop rready, go to RSP.
  - RSP: rsp_valid=1, held stable until rsp_ready. Then go to IDLE with req_ready=1 next cycle.
- Only one transaction is in flight. req_ready=0 in every state except IDLE.
- AXI rules:
  - Once asserted, a valid is never deasserted before its handshake.
  - Payload stays stable while valid is asserted.
  - Valids never depend combinationally on ready.
- Minimum latency, zero-wait responder: request accept at cycle 0; aw/w valid at 1; b handshake at 2 earliest; rsp_valid at 3.
- bvalid/rvalid arriving in a state that does not expect them is ignored (bready/rready low).
- Reset mid-transaction aborts immediately: all valids drop, the response is lost, state=IDLE.

Optional Feature:
- Macro: AXIL_MASTER_REQ_BUF_EN.
- Defined: adds a one-entry request buffer. req_ready=1 whenever the buffer is empty, including while a transaction is in flight. A buffered request launches the cycle after RSP completes. Back-to-back issue gap is 1 cycle; request order is preserved.
- Undefined: no buffer; req_ready is asserted only in IDLE as described above.

Test Plan:
- Write addr=0x0010, wdata=0xDEADBEEF, wstrb=4'hF against the team's AXI-Lite RAM -> awvalid/wvalid at cycle 1; rsp_valid with rsp_err=0 and rsp_rdata=0. A subsequent read of 0x0010 returns rsp_rdata=0xDEADBEEF.
- Partial write wstrb=4'b0010, wdata=0x0000AB00 over 0xDEADBEEF, then read -> 0xDEADABEF.
- Stalled responder: wready delayed 3 cycles after awready, rvalid delayed 5 cycles -> valids held stable, no duplicate handshakes, exactly one rsp per request.
- Responder returns bresp=2'b10, then rresp=2'b11 with rdata=0x12345678 -> rsp_err=1 both times; rsp_rdata=0x12345678 on the read.
- rsp_ready held low for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready stays 0 (without AXIL_MASTER_REQ_BUF_EN).
- Assert rst while in WR with awvalid=1 -> all valids 0 asynchronously, no response; the next request completes normally.
